// File: rtl/proc16_pkg.sv
// proc16_pkg
//   Shared widths for the 16-bit processor datapath.
//   DATA_W   : operand / register width
//   ADDR_W   : register address width
//   NUM_REGS : number of architectural registers (2**ADDR_W)
//   CTRL_W   : width of the opaque decoded-control bundle
//   reg_addr_t / word_t / ctrl_t are the matching vector types.
package proc16_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int CTRL_W   = 8;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [CTRL_W-1:0] ctrl_t;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// operand_fetch_stage_if
//   Bundles the handshake, register-file and write-back snoop signals of the
//   operand fetch stage.
//   slave  : the stage itself (consumes in_*, rf_read_data_*, wb_*, out_ready, flush)
//   master : the surrounding pipeline / register file / execute stage
interface operand_fetch_stage_if;
    import proc16_pkg::*;

    logic      flush;

    logic      in_valid;
    logic      in_ready;
    reg_addr_t in_src1;
    reg_addr_t in_src2;
    reg_addr_t in_dest;
    logic      in_dest_we;
    ctrl_t     in_ctrl;

    reg_addr_t rf_read_addr_1;
    reg_addr_t rf_read_addr_2;
    word_t     rf_read_data_1;
    word_t     rf_read_data_2;

    logic      wb_en;
    reg_addr_t wb_dest;
    word_t     wb_data;

    logic      out_valid;
    logic      out_ready;
    word_t     out_op1;
    word_t     out_op2;
    reg_addr_t out_dest;
    logic      out_dest_we;
    ctrl_t     out_ctrl;

    modport slave (
        input  flush,
        input  in_valid, in_src1, in_src2, in_dest, in_dest_we, in_ctrl,
        output in_ready,
        output rf_read_addr_1, rf_read_addr_2,
        input  rf_read_data_1, rf_read_data_2,
        input  wb_en, wb_dest, wb_data,
        output out_valid, out_op1, out_op2, out_dest, out_dest_we, out_ctrl,
        input  out_ready
    );

    modport master (
        output flush,
        output in_valid, in_src1, in_src2, in_dest, in_dest_we, in_ctrl,
        input  in_ready,
        input  rf_read_addr_1, rf_read_addr_2,
        output rf_read_data_1, rf_read_data_2,
        output wb_en, wb_dest, wb_data,
        input  out_valid, out_op1, out_op2, out_dest, out_dest_we, out_ctrl,
        output out_ready
    );

endinterface

// File: rtl/opf_scoreboard.sv
// opf_scoreboard
//   One busy bit per architectural register, marking a write still in flight.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     flush               clears every busy bit on the next edge
//     set_en / set_addr   mark a register busy (newly issued writer)
//     clr_en / clr_addr   clear a register (write-back seen)
//     q*_addr / q*_busy   three combinational lookups of the registered vector
//     busy                full registered busy vector
//   When set and clear target the same register in one cycle the set wins,
//   since the new writer is younger than the one completing.
module opf_scoreboard
    import proc16_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                set_en,
    input  reg_addr_t           set_addr,
    input  logic                clr_en,
    input  reg_addr_t           clr_addr,
    input  reg_addr_t           q1_addr,
    input  reg_addr_t           q2_addr,
    input  reg_addr_t           q3_addr,
    output logic                q1_busy,
    output logic                q2_busy,
    output logic                q3_busy,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
            always_comb begin
                busy_next[gi] = busy_reg[gi];
                if (flush) begin
                    busy_next[gi] = 1'b0;
                end else if (set_en && (set_addr == reg_addr_t'(gi))) begin
                    busy_next[gi] = 1'b1;
                end else if (clr_en && (clr_addr == reg_addr_t'(gi))) begin
                    busy_next[gi] = 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign q1_busy = busy_reg[q1_addr];
    assign q2_busy = busy_reg[q2_addr];
    assign q3_busy = busy_reg[q3_addr];
    assign busy    = busy_reg;

endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
//   Decode-to-execute stage: reads the register file, stalls on RAW/WAW
//   hazards tracked by an 8-entry scoreboard, and registers operands plus
//   pass-through control for execute (latency 1, full throughput).
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset (priority over flush)
//     bus          operand_fetch_stage_if.slave: flush, in_* handshake,
//                  rf_read_addr/data_*, wb_* snoop, out_* handshake
//   Build option:
//     OPF_FORWARDING_EN  bypass wb_data onto matching sources in the wb cycle;
//                        undefined -> operands only from the register file.
module operand_fetch_stage
    import proc16_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    operand_fetch_stage_if.slave   bus
);

    logic src1_busy, src2_busy, dest_busy;
    logic fwd_src1, fwd_src2, fwd_dest;
    logic hazard, in_ready, accept;
    word_t op1_next, op2_next;
    logic [NUM_REGS-1:0] busy_vec;

    logic      out_valid_reg;
    word_t     out_op1_reg;
    word_t     out_op2_reg;
    reg_addr_t out_dest_reg;
    logic      out_dest_we_reg;
    ctrl_t     out_ctrl_reg;

    opf_scoreboard u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (bus.flush),
        .set_en   (accept && bus.in_dest_we),
        .set_addr (bus.in_dest),
        .clr_en   (bus.wb_en),
        .clr_addr (bus.wb_dest),
        .q1_addr  (bus.in_src1),
        .q2_addr  (bus.in_src2),
        .q3_addr  (bus.in_dest),
        .q1_busy  (src1_busy),
        .q2_busy  (src2_busy),
        .q3_busy  (dest_busy),
        .busy     (busy_vec)
    );

`ifdef OPF_FORWARDING_EN
    // A write-back landing this cycle resolves the hazard immediately.
    assign fwd_src1 = bus.wb_en && (bus.wb_dest == bus.in_src1);
    assign fwd_src2 = bus.wb_en && (bus.wb_dest == bus.in_src2);
    assign fwd_dest = bus.wb_en && (bus.wb_dest == bus.in_dest);
    assign op1_next = fwd_src1 ? bus.wb_data : bus.rf_read_data_1;
    assign op2_next = fwd_src2 ? bus.wb_data : bus.rf_read_data_2;
`else
    // No bypass: the scoreboard clears at the wb edge, so the source is
    // released the cycle after, when the register file holds the value.
    assign fwd_src1 = 1'b0;
    assign fwd_src2 = 1'b0;
    assign fwd_dest = 1'b0;
    assign op1_next = bus.rf_read_data_1;
    assign op2_next = bus.rf_read_data_2;
`endif

    assign hazard = (src1_busy && !fwd_src1)
                 || (src2_busy && !fwd_src2)
                 || (bus.in_dest_we && dest_busy && !fwd_dest);

    assign in_ready = !bus.flush && !hazard && (!out_valid_reg || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg   <= 1'b0;
            out_op1_reg     <= '0;
            out_op2_reg     <= '0;
            out_dest_reg    <= '0;
            out_dest_we_reg <= 1'b0;
            out_ctrl_reg    <= '0;
        end else if (bus.flush) begin
            out_valid_reg   <= 1'b0;
        end else if (accept) begin
            out_valid_reg   <= 1'b1;
            out_op1_reg     <= op1_next;
            out_op2_reg     <= op2_next;
            out_dest_reg    <= bus.in_dest;
            out_dest_we_reg <= bus.in_dest_we;
            out_ctrl_reg    <= bus.in_ctrl;
        end else if (bus.out_ready) begin
            out_valid_reg   <= 1'b0;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.rf_read_addr_1 = bus.in_src1;
    assign bus.rf_read_addr_2 = bus.in_src2;
    assign bus.out_valid      = out_valid_reg;
    assign bus.out_op1        = out_op1_reg;
    assign bus.out_op2        = out_op2_reg;
    assign bus.out_dest       = out_dest_reg;
    assign bus.out_dest_we    = out_dest_we_reg;
    assign bus.out_ctrl       = out_ctrl_reg;

    // Full vector is only observed from outside the module hierarchy.
    logic unused_busy;
    assign unused_busy = ^busy_vec;

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    operand_fetch_stage_if bus ();

    operand_fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register-file model: combinational read, written on the wb bus.
    logic [15:0] rf [8];
    logic        rf_init;
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'(16'h0011 * i);
        end else if (bus.wb_en) begin
            rf[bus.wb_dest] <= bus.wb_data;
        end
    end
    assign bus.rf_read_data_1 = rf[bus.rf_read_addr_1];
    assign bus.rf_read_data_2 = rf[bus.rf_read_addr_2];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s1, input logic [2:0] s2,
                         input logic [2:0] d, input logic we, input logic [7:0] c);
        bus.in_valid   = v;
        bus.in_src1    = s1;
        bus.in_src2    = s2;
        bus.in_dest    = d;
        bus.in_dest_we = we;
        bus.in_ctrl    = c;
    endtask

    task automatic wb(input logic en, input logic [2:0] d, input logic [15:0] data);
        bus.wb_en   = en;
        bus.wb_dest = d;
        bus.wb_data = data;
    endtask

    typedef struct {
        logic [2:0]  src1;
        logic [2:0]  src2;
        logic [2:0]  dest;
        logic [7:0]  ctrl;
        logic [15:0] op1;
        logic [15:0] op2;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{3'd1, 3'd2, 3'd0, 8'h11, 16'h0011, 16'h0022};
        vecs[1] = '{3'd3, 3'd4, 3'd5, 8'h22, 16'h0033, 16'h0044};
        vecs[2] = '{3'd0, 3'd7, 3'd1, 8'h33, 16'h0000, 16'h0077};
        vecs[3] = '{3'd5, 3'd5, 3'd2, 8'h44, 16'h0055, 16'h0055};
        vecs[4] = '{3'd6, 3'd1, 3'd7, 8'h55, 16'h0066, 16'h0011};
        vecs[5] = '{3'd7, 3'd0, 3'd3, 8'h66, 16'h0077, 16'h0000};

        rst_n = 1'b0;
        rf_init = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
        wb(1'b0, 3'd0, 16'h0000);
        cyc();
        cyc();

        // Reset state
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_op1", 32'(bus.out_op1), 32'd0);
        check("rst_op2", 32'(bus.out_op2), 32'd0);
        check("rst_dest", 32'(bus.out_dest), 32'd0);
        check("rst_dest_we", 32'(bus.out_dest_we), 32'd0);
        check("rst_ctrl", 32'(bus.out_ctrl), 32'd0);
        check("rst_busy", 32'(dut.u_sb.busy_reg), 32'd0);
        rst_n = 1'b1;
        rf_init = 1'b0;

        // No-hazard table, back-to-back at full throughput
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].src1, vecs[i].src2, vecs[i].dest, 1'b0, vecs[i].ctrl);
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
            check($sformatf("v%0d_rf_addr1", i), 32'(bus.rf_read_addr_1), 32'(vecs[i].src1));
            cyc();
            $display("vec %0d: src1=%0d src2=%0d op1=%h op2=%h", i, vecs[i].src1, vecs[i].src2,
                     bus.out_op1, bus.out_op2);
            check($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("v%0d_op1", i), 32'(bus.out_op1), 32'(vecs[i].op1));
            check($sformatf("v%0d_op2", i), 32'(bus.out_op2), 32'(vecs[i].op2));
            check($sformatf("v%0d_dest", i), 32'(bus.out_dest), 32'(vecs[i].dest));
            check($sformatf("v%0d_ctrl", i), 32'(bus.out_ctrl), 32'(vecs[i].ctrl));
        end
        drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
        cyc();
        check("idle_valid", 32'(bus.out_valid), 32'd0);

        // RAW: writer of R3, then reader of R3, wb two cycles after issue
        drive(1'b1, 3'd0, 3'd0, 3'd3, 1'b1, 8'h01);
        cyc();
        check("raw_busy3", 32'(dut.u_sb.busy_reg), 32'h08);
        check("raw_wr_dest_we", 32'(bus.out_dest_we), 32'd1);
        drive(1'b1, 3'd3, 3'd0, 3'd5, 1'b0, 8'h02);
        #1;
        check("raw_stall1", 32'(bus.in_ready), 32'd0);
        cyc();
        check("raw_stall_valid", 32'(bus.out_valid), 32'd0);
        wb(1'b1, 3'd3, 16'hBEEF);
        #1;
`ifdef OPF_FORWARDING_EN
        check("raw_fwd_ready", 32'(bus.in_ready), 32'd1);
        cyc();
        wb(1'b0, 3'd0, 16'h0000);
`else
        check("raw_wbcyc_stall", 32'(bus.in_ready), 32'd0);
        cyc();
        wb(1'b0, 3'd0, 16'h0000);
        check("raw_wbcyc_valid", 32'(bus.out_valid), 32'd0);
        #1;
        check("raw_after_ready", 32'(bus.in_ready), 32'd1);
        cyc();
`endif
        $display("raw: op1=%h valid=%0d", bus.out_op1, bus.out_valid);
        check("raw_valid", 32'(bus.out_valid), 32'd1);
        check("raw_op1", 32'(bus.out_op1), 32'hBEEF);
        check("raw_ctrl", 32'(bus.out_ctrl), 32'h02);
        check("raw_busy_clear", 32'(dut.u_sb.busy_reg), 32'd0);

        // Backpressure: held output, stalled input, no busy change
        drive(1'b1, 3'd1, 3'd2, 3'd6, 1'b1, 8'hA5);
        cyc();
        bus.out_ready = 1'b0;
        drive(1'b1, 3'd1, 3'd0, 3'd7, 1'b1, 8'h5A);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d_in_ready", k), 32'(bus.in_ready), 32'd0);
            cyc();
            $display("bp %0d: valid=%0d op1=%h ctrl=%h", k, bus.out_valid, bus.out_op1, bus.out_ctrl);
            check($sformatf("bp%0d_valid", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp%0d_op1", k), 32'(bus.out_op1), 32'h0011);
            check($sformatf("bp%0d_op2", k), 32'(bus.out_op2), 32'h0022);
            check($sformatf("bp%0d_ctrl", k), 32'(bus.out_ctrl), 32'hA5);
            check($sformatf("bp%0d_busy", k), 32'(dut.u_sb.busy_reg), 32'h40);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        cyc();
        check("bp_next_ctrl", 32'(bus.out_ctrl), 32'h5A);
        check("bp_next_busy", 32'(dut.u_sb.busy_reg), 32'hC0);
        drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
        wb(1'b1, 3'd6, 16'h6666);
        cyc();
        wb(1'b1, 3'd7, 16'h7777);
        cyc();
        wb(1'b0, 3'd0, 16'h0000);
        check("bp_cleanup_busy", 32'(dut.u_sb.busy_reg), 32'd0);

        // Same-cycle clear/set on R4
        drive(1'b1, 3'd0, 3'd0, 3'd4, 1'b1, 8'h04);
        cyc();
        check("cs_busy_pending", 32'(dut.u_sb.busy_reg), 32'h10);
        drive(1'b1, 3'd0, 3'd0, 3'd4, 1'b1, 8'h44);
        wb(1'b1, 3'd4, 16'h4444);
        #1;
`ifdef OPF_FORWARDING_EN
        check("cs_ready", 32'(bus.in_ready), 32'd1);
        cyc();
        wb(1'b0, 3'd0, 16'h0000);
`else
        check("cs_waw_stall", 32'(bus.in_ready), 32'd0);
        cyc();
        wb(1'b0, 3'd0, 16'h0000);
        check("cs_cleared", 32'(dut.u_sb.busy_reg), 32'h00);
        cyc();
`endif
        drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
        check("cs_set_wins", 32'(dut.u_sb.busy_reg), 32'h10);
        check("cs_ctrl", 32'(bus.out_ctrl), 32'h44);
        wb(1'b1, 3'd4, 16'h4445);
        cyc();
        wb(1'b0, 3'd0, 16'h0000);

        // Flush with busy=0x0F and a held output
        for (int r = 0; r < 4; r++) begin
            drive(1'b1, 3'd7, 3'd7, 3'(r), 1'b1, 8'(8'hF0 + r));
            cyc();
        end
        check("fl_busy_pre", 32'(dut.u_sb.busy_reg), 32'h0F);
        check("fl_valid_pre", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b0;
        bus.flush = 1'b1;
        drive(1'b1, 3'd7, 3'd7, 3'd5, 1'b1, 8'hEE);
        #1;
        check("fl_in_ready", 32'(bus.in_ready), 32'd0);
        cyc();
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
        $display("flush: valid=%0d busy=%h", bus.out_valid, dut.u_sb.busy_reg);
        check("fl_valid", 32'(bus.out_valid), 32'd0);
        check("fl_busy", 32'(dut.u_sb.busy_reg), 32'd0);
        cyc();
        check("fl_not_delivered", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of a stall
        drive(1'b1, 3'd0, 3'd0, 3'd2, 1'b1, 8'h21);
        cyc();
        bus.out_ready = 1'b0;
        drive(1'b1, 3'd2, 3'd1, 3'd6, 1'b0, 8'h62);
        #1;
        check("rs_stall", 32'(bus.in_ready), 32'd0);
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("rs_valid", 32'(bus.out_valid), 32'd0);
        check("rs_op1", 32'(bus.out_op1), 32'd0);
        check("rs_ctrl", 32'(bus.out_ctrl), 32'd0);
        check("rs_dest", 32'(bus.out_dest), 32'd0);
        check("rs_dest_we", 32'(bus.out_dest_we), 32'd0);
        check("rs_busy", 32'(dut.u_sb.busy_reg), 32'd0);
        #1;
        check("rs_ready_after", 32'(bus.in_ready), 32'd1);
        cyc();
        drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
        $display("post-reset: valid=%0d op1=%h op2=%h", bus.out_valid, bus.out_op1, bus.out_op2);
        check("rs_first_valid", 32'(bus.out_valid), 32'd1);
        check("rs_first_op1", 32'(bus.out_op1), 32'h0022);
        check("rs_first_op2", 32'(bus.out_op2), 32'h0011);
        check("rs_first_ctrl", 32'(bus.out_ctrl), 32'h62);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
